richardjsun_counter: RTL and testbench



---
 rtl/richardjsun_counter.sv | 48 ++++
 tb/tb_richardjsun_counter.sv | 95 +++++++++
 2 files changed

// File: rtl/richardjsun_counter.sv
// richardjsun_counter: 8-bit prescaled up/down counter tile with load, clear and Gray output
module richardjsun_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [7:0] count;
  logic [2:0] pre;
  logic hold, dir, load, clr, out_mode, tick;
  logic [1:0] sel;
  logic unused;
  assign hold = ui_in[0];
  assign dir = ui_in[1];
  assign load = ui_in[2];
  assign clr = ui_in[3];
  assign sel = ui_in[5:4];
  assign out_mode = ui_in[6];
  assign unused = ui_in[7];
  // tick is decoded from the prescaler value before it increments
  assign tick = sel == 2'd0 ? 1'b1 :
                sel == 2'd1 ? pre[0] :
                sel == 2'd2 ? &pre[1:0] : &pre;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'h00;
      pre <= 3'd0;
    end else if (ena) begin
      if (clr) begin
        count <= 8'h00;
        pre <= 3'd0;
      end else if (load) begin
        count <= uio_in;
        pre <= 3'd0;
      end else if (!hold) begin
        pre <= pre + 3'd1;
        if (tick) count <= dir ? count - 8'd1 : count + 8'd1;
      end
    end
  end
  assign uo_out = out_mode ? count ^ (count >> 1) : count;
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;
endmodule

// File: tb/tb_richardjsun_counter.sv
// tb_richardjsun_counter: directed vectors for the counter tile
module tb_richardjsun_counter;
  logic clk = 1'b0;
  logic rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int errors = 0;
  int checks = 0;
  richardjsun_counter dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    #2;
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'h00);
    ui_in = 8'h40;
    #1 check("rst_gray", uo_out, 8'h00);
    ui_in = 8'h00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step(1);
      check("count_up", uo_out, 8'(e));
    end
    ui_in = 8'h08;
    step(1); check("clr", uo_out, 8'h00);
    ui_in = 8'h02;
    step(1); check("down_ff", uo_out, 8'hFF);
    step(1); check("down_fe", uo_out, 8'hFE);
    step(1); check("down_fd", uo_out, 8'hFD);
    ui_in = 8'h04; uio_in = 8'hFE;
    step(1); check("load_fe", uo_out, 8'hFE);
    ui_in = 8'h00;
    step(1); check("up_ff", uo_out, 8'hFF);
    step(1); check("wrap_00", uo_out, 8'h00);
    ui_in = 8'h05; uio_in = 8'hA5;
    step(1); check("load_hold", uo_out, 8'hA5);
    ui_in = 8'h0C;
    step(1); check("clr_load", uo_out, 8'h00);
    ui_in = 8'h00;
    step(3); check("up3", uo_out, 8'h03);
    ui_in = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step(1); check("hold", uo_out, 8'h03);
    end
    ena = 1'b0; ui_in = 8'h08;
    for (int i = 0; i < 3; i++) begin
      step(1); check("ena_off", uo_out, 8'h03);
    end
    ena = 1'b1; ui_in = 8'h00;
    step(1); check("ena_on", uo_out, 8'h04);
    rst_n = 1'b0;
    #1 check("async_rst", uo_out, 8'h00);
    step(1);
    rst_n = 1'b1; ui_in = 8'h30;
    for (int e = 1; e <= 24; e++) begin
      step(1);
      check("pre8", uo_out, 8'(e / 8));
    end
    ui_in = 8'h10;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      check("pre2", uo_out, 8'(3 + e / 2));
    end
    ui_in = 8'h04; uio_in = 8'h05;
    step(1); check("load_05", uo_out, 8'h05);
    ui_in = 8'h41;
    #1 check("gray_05", uo_out, 8'h07);
    ui_in = 8'h04; uio_in = 8'hFF;
    step(1);
    ui_in = 8'h41;
    #1 check("gray_ff", uo_out, 8'h80);
    ui_in = 8'h00;
    step(3); check("pre_rst", uo_out, 8'h02);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check("mid_rst", uo_out, 8'h00);
    step(2); check("rst_held", uo_out, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
